// File: rtl/node_mix_array_stream_port.sv
// node_mix_array_stream_port: burst initiator that loads a node-mix array from a stream
// or streams it back out through a 2-entry output buffer.
module node_mix_array_stream_port #(
    parameter int DataWidth    = 32,
    parameter int AddressRange = 32,
    parameter int AddressWidth = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [AddressWidth-1:0] base,
    input  logic [AddressWidth:0]   len,
    output logic                    busy,
    output logic                    done,
    input  logic [DataWidth-1:0]    s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DataWidth-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    output logic                    we0,
    output logic [DataWidth-1:0]    d0,
    output logic [AddressWidth-1:0] address1,
    output logic                    ce1,
    input  logic [DataWidth-1:0]    q1
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;
    localparam logic [AddressWidth:0] RANGE = (AddressWidth+1)'(AddressRange);
    state_t state, state_nx;
    logic [AddressWidth-1:0] base_r, addr;
    logic [AddressWidth:0] len_r, idx, sum;
    logic [DataWidth-1:0] fifo [2];
    logic rd_ptr, wr_ptr, inflight, wr, pop, last;
    logic [1:0] count, occ;

    assign sum = {1'b0, base_r} + {1'b0, idx[AddressWidth-1:0]};
    assign addr = AddressWidth'(sum >= RANGE ? sum - RANGE : sum);
    assign last = idx == len_r - 1'b1;
    assign wr = state == WRITE && s_valid;
    assign pop = m_valid && m_ready;
    // a word leaving this cycle frees its slot for a read issued in the same cycle
    assign occ = count - {1'b0, pop};
    assign ce1 = state == READ && occ + {1'b0, inflight} < 2'd2;
    assign s_ready = state == WRITE;
    assign ce0 = wr;
    assign we0 = wr;
    assign address0 = wr ? addr : '0;
    assign d0 = wr ? s_data : '0;
    assign address1 = ce1 ? addr : '0;
    assign m_valid = count != 2'd0;
    assign m_data = m_valid ? fifo[rd_ptr] : '0;
    assign busy = state == WRITE || state == READ || state == FLUSH;
    assign done = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = len == '0 ? DONE : (mode ? READ : WRITE);
            WRITE:   if (wr && last) state_nx = DONE;
            READ:    if (ce1 && last) state_nx = FLUSH;
            FLUSH:   if (count == 2'd0 && !inflight) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            base_r   <= '0;
            len_r    <= '0;
            idx      <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                base_r <= base;
                len_r  <= len;
                idx    <= '0;
            end else if (wr || ce1) begin
                idx <= idx + 1'b1;
            end
            inflight <= ce1;
            if (inflight) begin
                fifo[wr_ptr] <= q1;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_node_mix_array_stream_port.sv
// tb_node_mix_array_stream_port: table-driven bursts against a modelled array, with
// scoreboards for array writes, read addresses and streamed read data.
module tb_node_mix_array_stream_port;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
    logic [4:0] base = '0;
    logic [5:0] len = '0;
    logic [31:0] s_data = '0, q1;
    logic busy, done, s_ready, m_valid, ce0, we0, ce1;
    logic [31:0] m_data, d0;
    logic [4:0] address0, address1;

    typedef struct {
        bit mode; int base; int len; int rdy; bit gap; int dseed;
        int lat; int span; int dgap; int dlat;
    } vec_t;
    vec_t vecs[9];
    logic [31:0] ram[32];
    logic [31:0] ref_mem[32];
    logic [36:0] wq[$];
    logic [31:0] rq[$];
    logic [4:0] aq[$];
    logic [36:0] we_exp;
    logic [31:0] rd_exp;
    logic [4:0] ra_exp;
    int checks = 0, passes = 0, cyc = 0, rdy_kind = 0, phase = 0, outst = 0;
    int start_cyc = -10, first_ce0 = -1, last_ce0 = -1, first_mv = -1, first_pop = -1;
    int last_pop = -1, done_cyc = -1, ndone = 0, npop = 0, busy_at1 = -1;
    int touch[32];

    node_mix_array_stream_port dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .len(len),
        .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .address0(address0), .ce0(ce0), .we0(we0), .d0(d0),
        .address1(address1), .ce1(ce1), .q1(q1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic bit outs_zero();
        return !(busy || done || s_ready || m_valid || ce0 || we0 || ce1) &&
               m_data == 32'd0 && d0 == 32'd0 && address0 == 5'd0 && address1 == 5'd0;
    endfunction

    task automatic clear_stats();
        start_cyc = -10; first_ce0 = -1; last_ce0 = -1; first_mv = -1; first_pop = -1;
        last_pop = -1; done_cyc = -1; ndone = 0; npop = 0; busy_at1 = -1;
        foreach (touch[i]) touch[i] = 0;
    endtask

    // array model: synchronous write on port 0, 1-cycle read latency on port 1
    initial begin
        q1 = '0;
        for (int i = 0; i < 32; i++) ram[i] = 32'(i);
        forever begin
            @(posedge clk);
            if (ce1) q1 <= ram[address1];
            if (ce0 && we0) ram[address0] <= d0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        phase = (phase + 1) % 3;
        m_ready = rdy_kind == 0 ? 1'b1 : rdy_kind == 1 ? (phase == 0) : 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(negedge clk);
        if (cyc == start_cyc + 1) busy_at1 = busy ? 1 : 0;
        if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
            chk(!busy, "busy_low_in_done", 64'(busy), 64'(0));
        end
        if (ce0) begin
            touch[address0]++;
            if (first_ce0 < 0) first_ce0 = cyc;
            last_ce0 = cyc;
            chk(wq.size() > 0, "write_expected", 64'(wq.size()), 64'(1));
            if (wq.size() > 0) begin
                we_exp = wq.pop_front();
                chk({we0, address0, d0} == {1'b1, we_exp}, "write_port",
                    64'({we0, address0, d0}), 64'({1'b1, we_exp}));
            end
        end
        if (ce1) begin
            touch[address1]++;
            chk(outst - ((m_valid && m_ready) ? 1 : 0) < 2, "occupancy", 64'(outst), 64'(1));
            outst++;
            chk(aq.size() > 0, "read_expected", 64'(aq.size()), 64'(1));
            if (aq.size() > 0) begin
                ra_exp = aq.pop_front();
                chk(address1 == ra_exp, "read_addr", 64'(address1), 64'(ra_exp));
            end
        end
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            npop++;
            outst--;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            chk(rq.size() > 0, "data_expected", 64'(rq.size()), 64'(1));
            if (rq.size() > 0) begin
                rd_exp = rq.pop_front();
                chk(m_data == rd_exp, "read_data", 64'(m_data), 64'(rd_exp));
            end
        end
    end

    task automatic run_vec(input int v);
        vec_t t;
        int k, g, ones, multi;
        bit pres;
        t = vecs[v];
        clear_stats();
        if (t.mode)
            for (int i = 0; i < t.len; i++) begin
                aq.push_back(5'((t.base + i) % 32));
                rq.push_back(ref_mem[(t.base + i) % 32]);
            end
        rdy_kind = t.rdy;
        @(posedge clk);
        #1;
        start = 1'b1; mode = t.mode; base = 5'(t.base); len = 6'(t.len); start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0; g = 0; pres = 1'b0;
        while (!t.mode && k < t.len && g < 200) begin
            if (!pres && (!t.gap || $urandom_range(0, 2) != 0)) begin
                pres = 1'b1;
                s_valid = 1'b1;
                s_data = 32'(t.dseed + k);
                wq.push_back({5'((t.base + k) % 32), s_data});
                ref_mem[(t.base + k) % 32] = s_data;
            end
            if (t.gap && g == 1) begin
                start = 1'b1; mode = 1'b1; base = 5'd20; len = 6'd5;
            end
            @(negedge clk);
            if (pres && s_ready) begin
                k++;
                pres = 1'b0;
            end
            @(posedge clk);
            #1;
            s_valid = pres;
            start = 1'b0;
            g++;
        end
        s_valid = 1'b0;
        g = 0;
        while (ndone == 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(ndone == 1, "done_pulses", 64'(ndone), 64'(1));
        chk(busy_at1 == (t.len != 0 ? 1 : 0), "busy_after_start", 64'(busy_at1), 64'(t.len != 0));
        if (t.lat >= 0)
            chk((t.mode ? first_mv : first_ce0) - start_cyc == t.lat, "first_latency",
                64'((t.mode ? first_mv : first_ce0) - start_cyc), 64'(t.lat));
        if (t.span >= 0)
            chk((t.mode ? last_pop - first_pop : last_ce0 - first_ce0) == t.span, "burst_span",
                64'(t.mode ? last_pop - first_pop : last_ce0 - first_ce0), 64'(t.span));
        if (t.dgap >= 0)
            chk(done_cyc - (t.mode ? last_pop : last_ce0) == t.dgap, "done_after_last",
                64'(done_cyc - (t.mode ? last_pop : last_ce0)), 64'(t.dgap));
        if (t.dlat >= 0)
            chk(done_cyc - start_cyc == t.dlat, "done_latency", 64'(done_cyc - start_cyc), 64'(t.dlat));
        chk(wq.size() + rq.size() + aq.size() == 0, "scoreboard_drained",
            64'(wq.size() + rq.size() + aq.size()), 64'(0));
        ones = 0; multi = 0;
        foreach (touch[i]) begin
            if (touch[i] == 1) ones++;
            if (touch[i] > 1) multi++;
        end
        chk(ones == t.len && multi == 0, "addresses_once", 64'(ones + 100 * multi), 64'(t.len));
        wq.delete(); rq.delete(); aq.delete();
    endtask

    initial begin
        int g;
        //          mode  base len rdy gap  dseed       lat span dgap dlat
        vecs[0] = '{1'b1, 30,  4,  0, 1'b0, 0,          3,  3,   2,   8};
        vecs[1] = '{1'b1, 0,   8,  1, 1'b0, 0,          3,  -1,  -1,  -1};
        vecs[2] = '{1'b1, 0,   8,  2, 1'b0, 0,          3,  -1,  -1,  -1};
        vecs[3] = '{1'b0, 0,   4,  0, 1'b0, 32'hA0,     1,  3,   1,   5};
        vecs[4] = '{1'b0, 10,  3,  0, 1'b1, 32'h5500,   -1, -1,  1,   -1};
        vecs[5] = '{1'b0, 7,   0,  0, 1'b0, 0,          -1, -1,  -1,  1};
        vecs[6] = '{1'b0, 5,   32, 0, 1'b0, 32'hC000,   1,  31,  1,   33};
        vecs[7] = '{1'b1, 5,   32, 0, 1'b0, 0,          3,  31,  2,   36};
        vecs[8] = '{1'b1, 3,   1,  1, 1'b0, 0,          3,  0,   -1,  -1};
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
        clear_stats();
        #12;
        chk(outs_zero(), "reset_outputs", 64'({busy, done, s_ready, m_valid, ce0, we0, ce1}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        for (int v = 0; v < 9; v++) run_vec(v);

        clear_stats();
        rdy_kind = 0;
        for (int i = 0; i < 8; i++) begin
            aq.push_back(5'(i));
            rq.push_back(ref_mem[i]);
        end
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1; base = 5'd0; len = 6'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        g = 0;
        while (npop < 3 && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk(npop == 3, "pops_before_abort", 64'(npop), 64'(3));
        reset = 1'b0;
        #1;
        chk(outs_zero(), "abort_outputs", 64'({busy, done, s_ready, m_valid, ce0, we0, ce1}), 64'(0));
        wq.delete(); rq.delete(); aq.delete();
        outst = 0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(ndone == 0, "abort_no_done", 64'(ndone), 64'(0));
        run_vec(0);
        run_vec(3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
